// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier with a start/done handshake.
// Each accepted operation takes WIDTH iterations, one per clock. The product
// is registered and only changes when an operation completes or on reset.
// Signed mode multiplies operand magnitudes and negates the result if needed.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; accepted in IDLE or DONE
//   signed_mode  1 = two's-complement operands/product; sampled with start
//   a, b         WIDTH-bit multiplicand / multiplier; sampled with start
//   busy         high while an operation is iterating
//   done         one-cycle pulse when product is updated
//   product      2*WIDTH-bit result, held between completions
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    product_q, product_d;

    logic [PW-1:0]    add_term;
    logic [PW-1:0]    acc_sum;

    // Magnitude of a two's-complement value; the most negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Partial product for the current iteration and the resulting accumulator.
    always_comb begin
        add_term = mplier_q[0] ? (PW'(mcand_q) << count_q) : '0;
        acc_sum  = acc_q + add_term;
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    acc_d    = '0;
                    count_d  = '0;
                    if (signed_mode) begin
                        mcand_d  = magnitude(a);
                        mplier_d = magnitude(b);
                        neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        mcand_d  = a;
                        mplier_d = b;
                        neg_d    = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end

            S_RUN: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // Last iteration: publish the (possibly negated) sum directly.
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state, including the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH = 2, 4 and 8 sharing one clock and reset.
module tb_seq_multiplier;

    logic clk;
    logic rst_n;

    logic       start2, sm2, busy2, done2;
    logic [1:0] a2, b2;
    logic [3:0] p2;

    logic       start4, sm4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_cmp = 0;
    int n_err = 0;

    bit          stab_en = 0;
    logic [15:0] last8;

    seq_multiplier #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .product(p2));

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(p4));

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer multiply of the interpreted operands, reduced mod 2^(2w).
    function automatic logic [15:0] ref_mul(input int w, input bit sm,
                                            input logic [7:0] av, input logic [7:0] bv);
        longint x, y, r, m;
        m = (longint'(1) << w) - 1;
        x = longint'(av) & m;
        y = longint'(bv) & m;
        if (sm && x[w-1]) x = x - (longint'(1) << w);
        if (sm && y[w-1]) y = y - (longint'(1) << w);
        r = x * y;
        r = r & ((longint'(1) << (2 * w)) - 1);
        return 16'(r);
    endfunction

    task automatic drive(input int w, input bit st, input bit sm,
                         input logic [7:0] av, input logic [7:0] bv);
        case (w)
            2: begin start2 = st; sm2 = sm; a2 = av[1:0]; b2 = bv[1:0]; end
            4: begin start4 = st; sm4 = sm; a4 = av[3:0]; b4 = bv[3:0]; end
            default: begin start8 = st; sm8 = sm; a8 = av; b8 = bv; end
        endcase
    endtask

    task automatic obs(input int w, output bit bz, output bit dn, output logic [15:0] p);
        case (w)
            2: begin bz = busy2; dn = done2; p = 16'(p2); end
            4: begin bz = busy4; dn = done4; p = 16'(p4); end
            default: begin bz = busy8; dn = done8; p = p8; end
        endcase
    endtask

    // One full operation: idle gap, start pulse, operands scrambled during RUN,
    // then latency, busy, product and single-cycle done are checked.
    task automatic do_op(input int w, input bit sm, input logic [7:0] av,
                         input logic [7:0] bv, input int gap);
        bit bz, dn;
        logic [15:0] p;
        int lat;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        drive(w, 1'b1, sm, av, bv);
        @(negedge clk);
        drive(w, 1'b0, ~sm, 8'($urandom), 8'($urandom));
        lat = 0;
        obs(w, bz, dn, p);
        while (!dn && lat < 40) begin
            check("busy_run", 64'(bz), 64'd1);
            @(negedge clk);
            lat++;
            obs(w, bz, dn, p);
        end
        check("latency", 64'(lat), 64'(w));
        check("product", 64'(p), 64'(ref_mul(w, sm, av, bv)));
        check("busy_done", 64'(bz), 64'd0);
        @(negedge clk);
        obs(w, bz, dn, p);
        check("done_one_cycle", 64'(dn), 64'd0);
    endtask

    // Product must not move except on a done pulse.
    always @(negedge clk) begin
        if (stab_en && !done8)
            check("stable8", 64'(p8), 64'(last8));
        last8 = p8;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit bz, dn;
        logic [15:0] p;
        int lat;
        int lat2;

        rst_n = 1'b0;
        drive(2, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);
        drive(8, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_prod4", 64'(p4), 64'd0);
        check("rst_prod8", 64'(p8), 64'd0);
        rst_n = 1'b1;

        // Unsigned basics at WIDTH=4.
        do_op(4, 0, 8'd3, 8'd3, 0);
        check("u3x3", 64'(p4), 64'h09);
        do_op(4, 0, 8'd15, 8'd15, 1);
        check("u15x15", 64'(p4), 64'hE1);

        // Signed corners at WIDTH=4.
        do_op(4, 1, 8'hD, 8'd5, 0);
        check("s_m3x5", 64'(p4), 64'hF1);
        do_op(4, 1, 8'h8, 8'h8, 2);
        check("s_m8xm8", 64'(p4), 64'h40);
        do_op(4, 1, 8'h8, 8'd7, 0);
        check("s_m8x7", 64'(p4), 64'hC8);
        do_op(4, 1, 8'd0, 8'hB, 0);
        check("s_0xm5", 64'(p4), 64'h00);

        // start held through RUN with new operands; back-to-back accept in DONE.
        @(negedge clk);
        drive(4, 1, 0, 8'd3, 8'd5);
        @(negedge clk);
        drive(4, 1, 0, 8'd7, 8'd9);
        lat = 0;
        obs(4, bz, dn, p);
        while (!dn && lat < 40) begin
            @(negedge clk);
            lat++;
            obs(4, bz, dn, p);
        end
        check("b2b_lat1", 64'(lat), 64'd4);
        check("b2b_prod1", 64'(p), 64'd15);
        lat2 = 0;
        do begin
            @(negedge clk);
            lat2++;
            obs(4, bz, dn, p);
        end while (!dn && lat2 < 40);
        drive(4, 0, 0, 0, 0);
        check("b2b_gap", 64'(lat2), 64'd5);
        check("b2b_prod2", 64'(p), 64'd63);
        @(negedge clk);
        check("b2b_done_low", 64'(done4), 64'd0);

        // Asynchronous reset at iteration 2 of an operation.
        @(negedge clk);
        drive(4, 1, 0, 8'd9, 8'd11);
        @(negedge clk);
        drive(4, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy4), 64'd0);
        check("arst_done", 64'(done4), 64'd0);
        check("arst_prod", 64'(p4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("arst_no_done", 64'(done4), 64'd0);
        end
        do_op(4, 0, 8'd6, 8'd7, 0);
        check("after_rst_6x7", 64'(p4), 64'h2A);

        // Exhaustive WIDTH=2 unsigned.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                do_op(2, 0, 8'(i), 8'(j), 0);

        // Randomised WIDTH=8, mixed modes and gaps.
        @(negedge clk);
        stab_en = 1;
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] av, bv;
            av = 8'($urandom);
            bv = 8'($urandom);
            if ($urandom_range(0, 15) == 0) av = 8'h80;
            if ($urandom_range(0, 15) == 0) bv = 8'h80;
            if ($urandom_range(0, 31) == 0) bv = 8'h00;
            do_op(8, 1'($urandom), av, bv, int'($urandom_range(0, 3)));
        end
        stab_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
